// File: rtl/acc_req_frontend_pkg.sv
// Request/response types exchanged with CVA6 over the accelerator interface.
// Field layout mirrors ariane_pkg so the frontend drops in unchanged.
package acc_req_frontend_pkg;

  localparam int unsigned XLEN        = 64;
  localparam int unsigned TransIdBits = 3;

  typedef struct packed {
    logic [31:0]            insn;
    logic [XLEN-1:0]        rs1;
    logic [XLEN-1:0]        rs2;
    logic [TransIdBits-1:0] trans_id;
    logic                   store_pending;
  } accelerator_req_t;

  typedef struct packed {
    logic [XLEN-1:0]        result;
    logic [TransIdBits-1:0] trans_id;
    logic                   error;
  } accelerator_resp_t;

endpackage

// File: rtl/acc_req_frontend_fifo.sv
// Generic synchronous FIFO (registered head, no fall-through) with full/empty flags.
module acc_req_fifo #(
  parameter type         T     = logic,
  parameter int unsigned Depth = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  T                mem [Depth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [PtrW:0]   count_q;
  logic            do_push;
  logic            do_pop;

  assign full_o  = (count_q == (PtrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage is not reset, so the head is forced to zero while empty.
  assign data_o  = empty_o ? T'('0) : mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) mem[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/acc_req_frontend.sv
// Accelerator receive stage: in-order request FIFO, in-flight limit and
// a one-entry response register back toward CVA6.
module acc_req_frontend
  import acc_req_frontend_pkg::*;
#(
  parameter int unsigned FifoDepth      = 4,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  accelerator_req_t    req_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  output accelerator_req_t    core_req_o,
  output logic                core_req_valid_o,
  input  logic                core_req_ready_i,
  input  accelerator_resp_t   core_resp_i,
  input  logic                core_resp_valid_i,
  output logic                core_resp_ready_o,
  output accelerator_resp_t   resp_o,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [CntWidth-1:0] outstanding_o,
  output logic                idle_o
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              resp_hs;
  logic              resp_load;
  logic [CntWidth-1:0] cnt_q;
  logic [CntWidth-1:0] cnt_d;
  accelerator_resp_t resp_q;
  logic              resp_valid_q;

  assign req_ready_o      = !fifo_full && (cnt_q < MaxCnt);
  assign push             = req_valid_i && req_ready_o;
  assign core_req_valid_o = !fifo_empty;
  assign pop              = core_req_valid_o && core_req_ready_i;

  acc_req_fifo #(
    .T     (accelerator_req_t),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (req_i),
    .pop_i   (pop),
    .data_o  (core_req_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign resp_hs           = resp_valid_q && resp_ready_i;
  assign core_resp_ready_o = !resp_valid_q || resp_ready_i;
  assign resp_load         = core_resp_valid_i && core_resp_ready_o;

  // Decrement saturates at zero; a handshake there is a protocol error.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, resp_hs})
      2'b10:   cnt_d = cnt_q + CntWidth'(1);
      2'b01:   cnt_d = (cnt_q == '0) ? '0 : cnt_q - CntWidth'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      resp_q       <= '0;
      resp_valid_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (resp_load) begin
        resp_q       <= core_resp_i;
        resp_valid_q <= 1'b1;
      end else if (resp_hs) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(resp_hs && (cnt_q == '0)))
        else $error("acc_req_frontend: response handshake with no outstanding request");
    end
  end

  assign resp_o        = resp_q;
  assign resp_valid_o  = resp_valid_q;
  assign outstanding_o = cnt_q;
  assign idle_o        = fifo_empty && (cnt_q == '0) && !resp_valid_q;

endmodule

// File: tb/tb_acc_req_frontend.sv
// Directed bench for acc_req_frontend: vector table plus hand sequences.
module tb_acc_req_frontend;
  import acc_req_frontend_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main instance (FifoDepth=4, MaxOutstanding=8)
  accelerator_req_t  req = '0, core_req;
  logic              req_valid = 1'b0, req_ready;
  logic              core_req_valid, core_req_ready = 1'b0;
  accelerator_resp_t core_resp = '0, resp;
  logic              core_resp_valid = 1'b0, core_resp_ready;
  logic              resp_valid, resp_ready = 1'b0;
  logic [3:0]        outstanding;
  logic              idle;

  // limit instance (MaxOutstanding=2)
  accelerator_req_t  l_req = '0, l_core_req;
  logic              l_req_valid = 1'b0, l_req_ready;
  logic              l_core_req_valid, l_core_req_ready = 1'b0;
  accelerator_resp_t l_core_resp = '0, l_resp;
  logic              l_core_resp_valid = 1'b0, l_core_resp_ready;
  logic              l_resp_valid, l_resp_ready = 1'b0;
  logic [1:0]        l_outstanding;
  logic              l_idle;

  acc_req_frontend #(.FifoDepth(4), .MaxOutstanding(8)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .req_i(req), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .core_req_o(core_req), .core_req_valid_o(core_req_valid), .core_req_ready_i(core_req_ready),
    .core_resp_i(core_resp), .core_resp_valid_i(core_resp_valid), .core_resp_ready_o(core_resp_ready),
    .resp_o(resp), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .outstanding_o(outstanding), .idle_o(idle)
  );

  acc_req_frontend #(.FifoDepth(4), .MaxOutstanding(2)) u_lim (
    .clk_i(clk), .rst_i(rst),
    .req_i(l_req), .req_valid_i(l_req_valid), .req_ready_o(l_req_ready),
    .core_req_o(l_core_req), .core_req_valid_o(l_core_req_valid), .core_req_ready_i(l_core_req_ready),
    .core_resp_i(l_core_resp), .core_resp_valid_i(l_core_resp_valid), .core_resp_ready_o(l_core_resp_ready),
    .resp_o(l_resp), .resp_valid_o(l_resp_valid), .resp_ready_i(l_resp_ready),
    .outstanding_o(l_outstanding), .idle_o(l_idle)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  function automatic accelerator_req_t mkreq(input logic [2:0] id);
    accelerator_req_t r;
    r.insn          = 32'h1000_0000 + 32'(id);
    r.rs1           = 64'(id) * 64'd3 + 64'h100;
    r.rs2           = ~64'(id);
    r.trans_id      = id;
    r.store_pending = id[0];
    return r;
  endfunction

  function automatic accelerator_resp_t mkresp(input logic [63:0] res, input logic [2:0] id);
    accelerator_resp_t r;
    r.result   = res;
    r.trans_id = id;
    r.error    = 1'b0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0; core_req_ready = 1'b0; core_resp_valid = 1'b0; resp_ready = 1'b0;
    l_req_valid = 1'b0; l_core_req_ready = 1'b0; l_core_resp_valid = 1'b0; l_resp_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       push;
    logic [2:0] id;
    logic       cresp_v;
    logic [2:0] cresp_id;
    logic       exp_cvalid;
    logic [2:0] exp_head;
    logic [3:0] exp_out;
    logic       exp_req_rdy;
    logic       exp_rvalid;
    logic [2:0] exp_rid;
    logic       exp_idle;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // push/pop ordering, responses, simultaneous push + response handshake
    //          push id cr_v cr_id cval head out rrdy rval rid idle
    vecs[0] = '{1, 1, 0, 0, 1, 1, 1, 1, 0, 0, 0};
    vecs[1] = '{1, 2, 0, 0, 1, 2, 2, 1, 0, 0, 0};
    vecs[2] = '{1, 3, 0, 0, 1, 3, 3, 1, 0, 0, 0};
    vecs[3] = '{0, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0};
    vecs[4] = '{0, 0, 1, 1, 0, 0, 3, 1, 1, 1, 0};
    vecs[5] = '{1, 4, 1, 2, 1, 4, 3, 1, 1, 2, 0};
    vecs[6] = '{0, 0, 1, 3, 0, 0, 2, 1, 1, 3, 0};
    vecs[7] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};
    vecs[8] = '{0, 0, 1, 4, 0, 0, 1, 1, 1, 4, 0};
    vecs[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};

    // ---- reset state
    do_reset();
    chk("rst_req_ready", 256'(req_ready), 256'(1));
    chk("rst_core_req_valid", 256'(core_req_valid), 256'(0));
    chk("rst_core_resp_ready", 256'(core_resp_ready), 256'(1));
    chk("rst_resp_valid", 256'(resp_valid), 256'(0));
    chk("rst_outstanding", 256'(outstanding), 256'(0));
    chk("rst_idle", 256'(idle), 256'(1));
    chk("rst_core_req_data", 256'(core_req), 256'(0));
    chk("rst_resp_data", 256'(resp), 256'(0));

    // ---- table: core always ready, CVA6 always ready
    core_req_ready = 1'b1;
    resp_ready     = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [255:0] act, exp;
      req_valid       = vecs[i].push;
      req             = mkreq(vecs[i].id);
      core_resp_valid = vecs[i].cresp_v;
      core_resp       = mkresp(64'hA000 + 64'(vecs[i].cresp_id), vecs[i].cresp_id);
      step();
      act = {core_req_valid, core_req_valid ? core_req : accelerator_req_t'('0),
             outstanding, req_ready, resp_valid,
             resp_valid ? resp : accelerator_resp_t'('0), idle};
      exp = {vecs[i].exp_cvalid,
             vecs[i].exp_cvalid ? mkreq(vecs[i].exp_head) : accelerator_req_t'('0),
             vecs[i].exp_out, vecs[i].exp_req_rdy, vecs[i].exp_rvalid,
             vecs[i].exp_rvalid ? mkresp(64'hA000 + 64'(vecs[i].exp_rid), vecs[i].exp_rid)
                                : accelerator_resp_t'('0),
             vecs[i].exp_idle};
      chk($sformatf("vec%0d", i), act, exp);
    end
    req_valid = 1'b0; core_resp_valid = 1'b0;

    // ---- FIFO full, blocked push, pop restores ready, full push+pop, wrap
    do_reset();
    resp_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      req_valid = 1'b1; req = mkreq(3'(i));
      step();
      if (i == 3) chk("full_ready_at3", 256'(req_ready), 256'(1));
    end
    chk("full_ready_at4", 256'(req_ready), 256'(0));
    chk("full_out4", 256'(outstanding), 256'(4));
    chk("full_head1", 256'(core_req), 256'(mkreq(3'd1)));
    req = mkreq(3'd5);
    step();
    chk("full_blocked_out", 256'(outstanding), 256'(4));
    req_valid = 1'b0; core_req_ready = 1'b1;
    step();
    core_req_ready = 1'b0;
    chk("full_pop_ready", 256'(req_ready), 256'(1));
    chk("full_pop_head2", 256'(core_req), 256'(mkreq(3'd2)));
    req_valid = 1'b1; req = mkreq(3'd5);
    step();
    chk("refull_ready", 256'(req_ready), 256'(0));
    chk("refull_out5", 256'(outstanding), 256'(5));
    req = mkreq(3'd6); core_req_ready = 1'b1;
    step();
    req_valid = 1'b0;
    chk("full_pushpop_out", 256'(outstanding), 256'(5));
    chk("full_pushpop_head3", 256'(core_req), 256'(mkreq(3'd3)));
    chk("full_pushpop_ready", 256'(req_ready), 256'(1));
    step();
    chk("drain_head4", 256'(core_req), 256'(mkreq(3'd4)));
    step();
    chk("drain_head5_wrap", 256'(core_req), 256'(mkreq(3'd5)));
    step();
    chk("drain_empty", 256'(core_req_valid), 256'(0));

    // ---- outstanding limit (MaxOutstanding=2 instance)
    do_reset();
    l_core_req_ready = 1'b1; l_resp_ready = 1'b1;
    l_req_valid = 1'b1; l_req = mkreq(3'd1);
    step();
    l_req = mkreq(3'd2);
    step();
    chk("lim_ready_at2", 256'(l_req_ready), 256'(0));
    chk("lim_out2", 256'(l_outstanding), 256'(2));
    l_req = mkreq(3'd3);
    step();
    chk("lim_blocked_out", 256'(l_outstanding), 256'(2));
    l_req_valid = 1'b0;
    l_core_resp_valid = 1'b1; l_core_resp = mkresp(64'h11, 3'd1);
    step();
    l_core_resp_valid = 1'b0;
    chk("lim_resp_loaded", 256'({l_resp_valid, l_outstanding}), 256'({1'b1, 2'd2}));
    step();
    chk("lim_after_hs_out", 256'(l_outstanding), 256'(1));
    chk("lim_after_hs_ready", 256'(l_req_ready), 256'(1));
    l_core_resp_valid = 1'b1; l_core_resp = mkresp(64'h22, 3'd2);
    step();
    l_core_resp_valid = 1'b0;
    step();
    chk("lim_drained", 256'({l_outstanding, l_idle}), 256'({2'd0, 1'b1}));
    l_core_req_ready = 1'b0; l_resp_ready = 1'b0;

    // ---- response backpressure and back-to-back throughput
    do_reset();
    core_req_ready = 1'b1;
    for (int i = 5; i <= 7; i++) begin
      req_valid = 1'b1; req = mkreq(3'(i));
      step();
    end
    req_valid = 1'b0;
    step();
    chk("bp_out3", 256'(outstanding), 256'(3));
    core_resp_valid = 1'b1; core_resp = mkresp(64'hDEAD, 3'd5); resp_ready = 1'b0;
    step();
    chk("bp_loaded", 256'({resp_valid, resp}), 256'({1'b1, mkresp(64'hDEAD, 3'd5)}));
    core_resp = mkresp(64'hBEEF, 3'd6);
    #1;
    chk("bp_core_resp_ready_low", 256'(core_resp_ready), 256'(0));
    step();
    chk("bp_hold1", 256'({resp_valid, resp, outstanding}), 256'({1'b1, mkresp(64'hDEAD, 3'd5), 4'd3}));
    step();
    chk("bp_hold2", 256'(resp), 256'(mkresp(64'hDEAD, 3'd5)));
    resp_ready = 1'b1;
    #1;
    chk("bp_core_resp_ready_high", 256'(core_resp_ready), 256'(1));
    step();
    chk("b2b_1", 256'({resp, outstanding}), 256'({mkresp(64'hBEEF, 3'd6), 4'd2}));
    core_resp = mkresp(64'h1234, 3'd7);
    step();
    chk("b2b_2", 256'({resp, outstanding}), 256'({mkresp(64'h1234, 3'd7), 4'd1}));
    core_resp_valid = 1'b0;
    step();
    chk("b2b_done", 256'({resp_valid, outstanding, idle}), 256'({1'b0, 4'd0, 1'b1}));

    // ---- reset mid-operation discards queue and pending response
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      req_valid = 1'b1; req = mkreq(3'(i));
      step();
    end
    req_valid = 1'b0;
    core_resp_valid = 1'b1; core_resp = mkresp(64'h77, 3'd1);
    step();
    core_resp_valid = 1'b0;
    chk("mid_pre", 256'({core_req_valid, resp_valid, outstanding}), 256'({1'b1, 1'b1, 4'd3}));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_post", 256'({core_req_valid, resp_valid, outstanding, idle, req_ready}),
        256'({1'b0, 1'b0, 4'd0, 1'b1, 1'b1}));
    core_req_ready = 1'b1; resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mid_quiet%0d", i), 256'({core_req_valid, resp_valid}), 256'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
